// File: rtl/rv32_data_bus_pkg.sv
// Shared types and helpers for the rv32 data-bus responder.
// Holds the FSM state enum, the legal byte-enable patterns and the address range check.
package rv32_data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // Byte-enable patterns accepted when error checking is enabled
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    function automatic logic be_is_legal(input logic [3:0] be);
        return be inside {BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3, BE_HALF0, BE_HALF1, BE_WORD};
    endfunction

    // True when addr lies in [base, base + 4*depth_words); 33-bit math avoids limit overflow
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                           input int unsigned depth_words);
        logic [32:0] off;
        logic [32:0] limit;
        off   = {1'b0, addr - base};
        limit = {1'b0, depth_words} << 2;
        return off < limit;
    endfunction

endpackage

// File: rtl/rv32_mod_data_responder_if.sv
// Data-bus handshake between an initiator (master) and the responder (slave).
interface rv32_mod_data_responder_if;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_data_i;
    logic [31:0] data_data_o;
    logic        data_ack;
    logic        data_err;

    modport master (
        output data_req, data_wr, data_be, data_addr, data_data_i,
        input  data_data_o, data_ack, data_err
    );

    modport slave (
        input  data_req, data_wr, data_be, data_addr, data_data_i,
        output data_data_o, data_ack, data_err
    );

endinterface

// File: rtl/rv32_mod_byte_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read data is the old word when a write hits the same address. Contents are never reset.
module rv32_mod_byte_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Lane-masked write and registered read on the single port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/rv32_mod_data_responder.sv
// Memory-backed responder for the rv32 data bus: IDLE -> [WAIT] -> RESP, one transfer at a time.
// Optional feature macro: RV32_DATA_RESP_ERR_EN enables out-of-range / illegal byte-enable errors;
// without it data_err is always 0, addresses wrap modulo the depth and any byte enable is accepted.
module rv32_mod_data_responder
    import rv32_data_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    rv32_mod_data_responder_if.slave   bus
);

    localparam int unsigned ADDR_W   = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    resp_state_e state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ack_q;
    logic        err_q;
    logic        rd_q;

    logic              req_wr;
    logic [3:0]        req_be;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              commit;
    logic              xfer_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

    // Select the live bus in IDLE (zero-wait capture) or the latched request otherwise,
    // and decide whether this edge enters RESP.
    always_comb begin
        if (state_q == IDLE) begin
            req_wr    = bus.data_wr;
            req_be    = bus.data_be;
            req_addr  = bus.data_addr;
            req_wdata = bus.data_data_i;
        end else begin
            req_wr    = wr_q;
            req_be    = be_q;
            req_addr  = addr_q;
            req_wdata = wdata_q;
        end

        // Gated by reset so nothing is committed while reset is held
        commit = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    commit = bus.data_req && NO_WAIT;
                WAIT:    commit = bus.data_req && (cnt_q == 4'd0);
                default: commit = 1'b0;
            endcase
        end

`ifdef RV32_DATA_RESP_ERR_EN
        xfer_err = !(addr_in_range(req_addr, BASE_ADDR, DEPTH_WORDS) && be_is_legal(req_be));
`else
        xfer_err = 1'b0;
`endif

        ram_addr = ADDR_W'((req_addr - BASE_ADDR) >> 2);
        ram_we   = (commit && req_wr && !xfer_err) ? req_be : 4'b0000;
    end

    rv32_mod_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Transfer FSM with registered ack/err/read-valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            ack_q <= commit && !xfer_err;
            err_q <= commit && xfer_err;
            rd_q  <= commit && !xfer_err && !req_wr;
            case (state_q)
                IDLE: begin
                    if (bus.data_req) begin
                        wr_q    <= bus.data_wr;
                        be_q    <= bus.data_be;
                        addr_q  <= bus.data_addr;
                        wdata_q <= bus.data_data_i;
                        if (NO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // Initiator withdrew: abandon the transfer silently
                    if (!bus.data_req) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_ack    = ack_q;
    assign bus.data_err    = err_q;
    assign bus.data_data_o = rd_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_rv32_mod_data_responder.sv
// Bench for rv32_mod_data_responder: a zero-wait and a three-wait instance against a word-array model.
module tb_rv32_mod_data_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst3;

    rv32_mod_data_responder_if b0();
    rv32_mod_data_responder_if b3();

    rv32_mod_data_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (0)
    ) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (b0)
    );

    rv32_mod_data_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (3)
    ) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (b3)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory per instance; known marks words whose full content has been written
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic req, input logic wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (s == 0) begin
            b0.data_req = req; b0.data_wr = wr; b0.data_be = be;
            b0.data_addr = addr; b0.data_data_i = wd;
        end else begin
            b3.data_req = req; b3.data_wr = wr; b3.data_be = be;
            b3.data_addr = addr; b3.data_data_i = wd;
        end
    endtask

    task automatic sample(input int s, output logic ack, output logic err, output logic [31:0] d);
        if (s == 0) begin
            ack = b0.data_ack; err = b0.data_err; d = b0.data_data_o;
        end else begin
            ack = b3.data_ack; err = b3.data_err; d = b3.data_data_o;
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input logic [3:0] be);
`ifdef RV32_DATA_RESP_ERR_EN
        return ((a - BASE) >= 4 * DEPTH) ||
               !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
        return 1'b0;
`endif
    endfunction

    // One complete transfer, predicting latency, ack/err and read data from the model
    task automatic xfer(input int s, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int          ws;
        int          i;
        int          n;
        bit          e;
        bit          got;
        bit          chk_data;
        logic [31:0] expd;
        logic        a;
        logic        er;
        logic [31:0] d;
        ws       = (s == 0) ? 0 : 3;
        i        = widx(addr);
        e        = exp_err(addr, be);
        expd     = 32'd0;
        chk_data = 1'b1;
        if (!wr && !e) begin
            if (known[s][i]) expd = mdl[s][i];
            else chk_data = 1'b0;
        end
        @(negedge clk);
        drive(s, 1'b1, wr, be, addr, wd);
        n   = 0;
        got = 1'b0;
        a   = 1'b0;
        er  = 1'b0;
        d   = 32'd0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            sample(s, a, er, d);
            if (a || er) got = 1'b1;
        end
        check({tag, "/latency"}, 32'(n), 32'(1 + ws));
        check({tag, "/ack"}, 32'(a), 32'(!e));
        check({tag, "/err"}, 32'(er), 32'(e));
        if (chk_data) check({tag, "/data"}, d, expd);
        drive(s, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        if (wr && !e) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mdl[s][i][8*k +: 8] = wd[8*k +: 8];
            end
            if (be == 4'b1111) known[s][i] = 1'b1;
        end
        @(negedge clk);
        sample(s, a, er, d);
        check({tag, "/ack_drop"}, 32'(a), 32'd0);
        check({tag, "/data_drop"}, d, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        a;
        logic        er;
        logic [31:0] d;
        int          acks;

        drive(0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        rst0 = 1'b1;
        rst3 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < DEPTH; w++) begin
                mdl[s][w]   = 32'd0;
                known[s][w] = 1'b0;
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        sample(0, a, er, d);
        check("rst0/ack", 32'(a), 32'd0);
        check("rst0/err", 32'(er), 32'd0);
        check("rst0/data", d, 32'd0);
        sample(3, a, er, d);
        check("rst3/ack", 32'(a), 32'd0);
        check("rst3/data", d, 32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // Full-word write/read, then lane merges
        xfer(0, 1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, "w_full");
        xfer(0, 1'b0, 4'b1111, 32'h10, 32'd0, "r_full");
        xfer(0, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, "w_b0");
        xfer(0, 1'b0, 4'b0001, 32'h10, 32'd0, "r_b0");
        xfer(0, 1'b1, 4'b1100, 32'h10, 32'h1234_0000, "w_h1");
        xfer(0, 1'b0, 4'b0010, 32'h10, 32'd0, "r_h1");
        check("merge_value", mdl[0][4], 32'h1234_BEAA);

        // Back-to-back reads with req held: ack, idle, ack, idle, ack, idle
        acks = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sample(0, a, er, d);
            if (k == 4) drive(0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
            check("b2b/ack", 32'(a), 32'(k % 2 == 0));
            check("b2b/data", d, (k % 2 == 0) ? mdl[0][4] : 32'd0);
            if (a) acks++;
        end
        check("b2b/count", 32'(acks), 32'd3);

        // Reset during a read response clears outputs at once
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'd0);
        @(negedge clk);
        sample(0, a, er, d);
        check("rstresp/ack_before", 32'(a), 32'd1);
        rst0 = 1'b1;
        #1;
        sample(0, a, er, d);
        check("rstresp/ack", 32'(a), 32'd0);
        check("rstresp/data", d, 32'd0);
        drive(0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        xfer(0, 1'b0, 4'b1111, 32'h10, 32'd0, "r_after_rst");

        // Randomized traffic against the model
        for (int w = 0; w < DEPTH; w++) begin
            xfer(0, 1'b1, 4'b1111, 32'(w * 4), $urandom, "init");
        end
        for (int t = 0; t < 40; t++) begin
            logic [31:0] ra;
            ra = (32'($urandom_range(0, 19)) << 2) | ($urandom & 32'h3);
            xfer(0, 1'($urandom), 4'($urandom), ra, $urandom, "rand");
        end

        // Three wait states: latency, abort, reset inside WAIT
        xfer(3, 1'b1, 4'b1111, 32'h14, 32'h1111_1111, "w3");
        xfer(3, 1'b0, 4'b1111, 32'h14, 32'd0, "r3");

        @(negedge clk);
        drive(3, 1'b1, 1'b1, 4'b1111, 32'h14, 32'h5555_5555);
        repeat (2) @(negedge clk);
        drive(3, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sample(3, a, er, d);
            if (a || er) acks++;
        end
        check("abort/no_resp", 32'(acks), 32'd0);
        xfer(3, 1'b0, 4'b1111, 32'h14, 32'd0, "abort/read");

        @(negedge clk);
        drive(3, 1'b1, 1'b1, 4'b1111, 32'h14, 32'hCAFE_F00D);
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        sample(3, a, er, d);
        check("rstwait/ack", 32'(a), 32'd0);
        check("rstwait/err", 32'(er), 32'd0);
        check("rstwait/data", d, 32'd0);
        drive(3, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        xfer(3, 1'b0, 4'b1111, 32'h14, 32'd0, "rstwait/read");

`ifdef RV32_DATA_RESP_ERR_EN
        xfer(0, 1'b0, 4'b1111, BASE + 4 * DEPTH, 32'd0, "err/range");
        xfer(0, 1'b1, 4'b0101, 32'h10, 32'hFFFF_FFFF, "err/be");
        xfer(0, 1'b0, 4'b1111, 32'h10, 32'd0, "err/unchanged");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32_mod_data_responder.md
RV32_MOD_DATA_RESPONDER -- requirements
Module: rv32_mod_data_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the backing store (power of two, >=4).
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4-aligned).
REQ-003 Parameter WAIT_STATES, 0, extra cycles inserted between request capture and response (0..15).
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-high; ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 data_req  input  1  initiator request; held until it sees data_ack or data_err.
REQ-008 data_wr  input  1  1 = write, 0 = read.
REQ-009 data_be  input  4  byte-lane enables; bit n covers bits 8n+7:8n.
REQ-010 data_addr  input  32  word-aligned byte address; bits 1:0 ignored.
REQ-011 data_data_i  input  32  write data, lane-positioned.
REQ-012 data_data_o  output  32  read data, full word, lane-positioned.
REQ-013 data_ack  output  1  one-cycle transfer completion.
REQ-014 data_err  output  1  one-cycle transfer failure.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; all outputs registered.
REQ-016 IDLE: when data_req=1 at a rising edge, the block SHALL latch wr, be, addr, wdata and go to WAIT if WAIT_STATES>0, else to RESP.
REQ-017 WAIT: a down-counter loaded with WAIT_STATES-1 SHALL decrement each cycle; at 0 the next state SHALL be RESP.
REQ-018 WAIT: if data_req=0 at any edge, the block SHALL abort to IDLE with no memory update and no ack/err.
REQ-019 RESP lasts exactly one cycle: data_ack=1 (or data_err=1, never both), then unconditionally IDLE.
REQ-020 Latency: request captured at edge k SHALL produce the response in cycle k+1+WAIT_STATES; throughput one transfer per WAIT_STATES+2 cycles.
REQ-021 data_req seen while in RESP SHALL be ignored (it is the transfer being completed); a new request is captured only from IDLE.
REQ-022 Writes SHALL update only lanes with data_be bit set, committed on the edge entering RESP; read data SHALL be the whole word regardless of data_be.
REQ-023 A write followed by a read of the same word SHALL return the written bytes merged with the old unselected bytes.
REQ-024 data_data_o SHALL be 0 in every cycle except a read RESP with data_ack=1.
REQ-025 Word index SHALL be (addr-BASE_ADDR)>>2 truncated to log2(DEPTH_WORDS) bits.

Reset
REQ-026 On reset assertion: state=IDLE, counter=0, data_ack=0, data_err=0, data_data_o=0 immediately; a transfer in progress SHALL be dropped with no memory update.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro RV32_DATA_RESP_ERR_EN defined: in RESP, data_err=1 (no ack, no write) when addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) or data_be is 0000 or not one of 0001,0010,0100,1000,0011,1100,1111.
REQ-029 Macro undefined: data_err SHALL be tied 0, addresses wrap modulo the depth, and any data_be value SHALL be accepted.

Structure
REQ-030 Package rv32_data_bus_pkg SHALL hold the state enum, legal byte-enable constants and the range-check function.
REQ-031 Storage SHALL be sub-module rv32_mod_byte_ram (synchronous, per-byte write enables, one read/write port); the FSM stays in the top module.

Verification
REQ-032 WAIT_STATES=0: write 0xDEADBEEF be=1111 @0x10, then read @0x10 -> ack on cycle k+1 each time, data_data_o=0xDEADBEEF.
REQ-033 Write 0x000000AA be=0001 @0x10 over 0xDEADBEEF, then read -> 0xDEADBEAA; then be=1100 with 0x12340000 -> 0x1234BEAA.
REQ-034 WAIT_STATES=3: read request held -> ack exactly 4 cycles after capture; req dropped after 2 cycles -> no ack, memory unchanged.
REQ-035 With RV32_DATA_RESP_ERR_EN: read @BASE_ADDR+4*DEPTH_WORDS -> data_err one cycle, data_ack=0; write be=0101 -> data_err, word unchanged.
REQ-036 Reset asserted in WAIT during write 0xCAFEF00D -> outputs 0 immediately, later read returns prior contents.
REQ-037 Back-to-back: req held continuously for 3 reads -> exactly 3 acks, each separated by one IDLE cycle (WAIT_STATES=0).
